// File: rtl/useq_pkg.sv
// Shared types and constants for the microprogram sequencer front end.
//   opcode_t : sequencer opcodes, same encoding as the sequencer
//   state_t  : run/halt/single-step controller states
//   CC_*     : special condition-select codes
package useq_pkg;

  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    JSRP = 4'd5,
    CJV  = 4'd6,
    JRP  = 4'd7,
    RFCT = 4'd8,
    RPCT = 4'd9,
    CRTN = 4'd10,
    CJPP = 4'd11,
    LDCT = 4'd12,
    LOOP = 4'd13,
    CONT = 4'd14,
    TWB  = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } state_t;

  localparam logic [3:0] CC_ALWAYS = 4'd0;
  localparam logic [3:0] CC_IRQ    = 4'd15;

  // Interrupt id width; covers up to 16 request lines.
  localparam int IDW = 4;

endpackage

// File: rtl/irq_arbiter.sv
// Prioritised interrupt-vector arbiter.
//   clk, reset : clock, synchronous active-high reset
//   irq        : request pulses, latched into the pending set
//   take       : a CJV issue whose condition passed; grants if anything pends
//   pending    : current pending set
//   id         : index of the lowest pending bit (bit 0 is highest priority)
//   irq_ack    : registered one-hot grant, one-cycle pulse after the grant
module irq_arbiter
  import useq_pkg::*;
#(
  parameter int NIRQ = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            take,
  output logic [NIRQ-1:0] pending,
  output logic [IDW-1:0]  id,
  output logic [NIRQ-1:0] irq_ack
);

  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] ack_q;
  logic [NIRQ-1:0] grant;

  // Priority encoder: the last assignment in the downward loop is the lowest set bit.
  always_comb begin
    id = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pend_q[i]) id = IDW'(i);
    end
  end

  // Isolating the lowest set bit gives the one-hot of id directly; zero when nothing pends.
  always_comb begin
    grant  = take ? (pend_q & (~pend_q + NIRQ'(1))) : '0;
    // A new pulse on the granted line in the grant cycle re-pends it.
    pend_d = (pend_q & ~grant) | irq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      ack_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ack_q  <= grant;
    end
  end

  assign pending = pend_q;
  assign irq_ack = ack_q;

endmodule

// File: rtl/useq_control.sv
// Front-end controller for the 12-bit microprogram sequencer.
// Registers the control-store word into a pipeline register, drives the
// sequencer instruction/condition/counter-load/carry-in inputs, muxes the
// sequencer D input, and runs the run/halt/single-step FSM.
//   clk, reset            : clock, synchronous active-high reset
//   run, step             : console run level, single-step pulse
//   halted, pipe_valid    : status
//   uw_*                  : control-store word fields
//   map_addr              : mapping PROM output
//   cond, irq / irq_ack   : condition flags, interrupt requests / acknowledge
//   seq_*                 : sequencer-facing signals (outputs and source enables)
//   dbg_state             : controller state for observation
//
// Handshake: there is no valid/ready pair; an issue cycle (RUN or STEP) both
// presents the pipelined word to the sequencer and loads the next word, while a
// hold cycle freezes the sequencer and leaves the pipeline untouched.
module useq_control
  import useq_pkg::*;
#(
  parameter int          NIRQ      = 8,
  parameter int          NCOND     = 15,
  parameter logic [11:0] VECT_BASE = 12'h100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  output logic             halted,
  output logic             pipe_valid,
  input  logic [3:0]       uw_op,
  input  logic [3:0]       uw_cc,
  input  logic             uw_pol,
  input  logic             uw_rld,
  input  logic [11:0]      uw_addr,
  input  logic [11:0]      map_addr,
  input  logic [NCOND-1:0] cond,
  input  logic [NIRQ-1:0]  irq,
  output logic [NIRQ-1:0]  irq_ack,
  output logic [3:0]       seq_I,
  output logic             seq_nCCEN,
  output logic             seq_nCC,
  output logic             seq_nRLD,
  output logic             seq_CI,
  output logic [11:0]      seq_D,
  input  logic             seq_nPL,
  input  logic             seq_nVECT,
  input  logic             seq_nMAP,
  output state_t           dbg_state
);

  state_t      state_q, state_d;
  logic [3:0]  pipe_op_q;
  logic [3:0]  pipe_cc_q;
  logic        pipe_pol_q;
  logic        pipe_rld_q;
  logic [11:0] pipe_addr_q;
  logic        pipe_valid_q;

  logic            issue;
  logic            capture;
  logic [15:0]     cond_ext;
  logic            sel;
  logic            cc_pass;
  logic            take;
  logic [NIRQ-1:0] pending;
  logic [IDW-1:0]  irq_id;
  logic [NIRQ-1:0] arb_ack;
  logic            unused_npl;

  // The pipeline-source enable is the default D source, so it needs no decode.
  assign unused_npl = seq_nPL;

  assign issue   = !reset && (state_q == RUN || state_q == STEP);
  assign capture = !reset && (state_q == ZERO || issue);

  // Condition select: 0 is unconditional, 15 is interrupt-pending, the rest
  // index the external flags; selects beyond NCOND read 0.
  always_comb begin
    cond_ext               = '0;
    cond_ext[NCOND-1:0]    = cond;
    sel                    = 1'b0;
    if (pipe_cc_q == CC_IRQ) begin
      sel = |pending;
    end else if (pipe_cc_q != CC_ALWAYS && int'(pipe_cc_q) <= NCOND) begin
      sel = cond_ext[pipe_cc_q - 4'd1];
    end
    cc_pass = (pipe_cc_q == CC_ALWAYS) || (sel ^ pipe_pol_q);
    take    = issue && (pipe_op_q == CJV) && cc_pass;
  end

  irq_arbiter #(.NIRQ(NIRQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .take    (take),
    .pending (pending),
    .id      (irq_id),
    .irq_ack (arb_ack)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ZERO:    state_d = run ? RUN : HALT;
      RUN:     state_d = run ? RUN : HALT;
      HALT:    state_d = run ? RUN : (step ? STEP : HALT);
      STEP:    state_d = HALT;
      default: state_d = ZERO;
    endcase
  end

  // Hold values are the defaults: CONT with no carry freezes the uPC.
  always_comb begin
    seq_I     = CONT;
    seq_CI    = 1'b0;
    seq_nRLD  = 1'b1;
    seq_nCCEN = 1'b1;
    seq_nCC   = 1'b1;
    halted    = 1'b0;
    if (reset) begin
      seq_I  = JZ;
      halted = 1'b1;
    end else begin
      case (state_q)
        ZERO: begin
          seq_I  = JZ;
          seq_CI = 1'b1;
          halted = 1'b1;
        end
        HALT: halted = 1'b1;
        default: begin
          seq_I    = pipe_op_q;
          seq_CI   = 1'b1;
          seq_nRLD = ~pipe_rld_q;
          if (pipe_cc_q != CC_ALWAYS) begin
            seq_nCCEN = 1'b0;
            seq_nCC   = ~(sel ^ pipe_pol_q);
          end
        end
      endcase
    end
  end

  // D mux: mapping PROM beats vector beats pipeline address.
  always_comb begin
    if (!seq_nMAP)       seq_D = map_addr;
    else if (!seq_nVECT) seq_D = VECT_BASE + {6'b0, irq_id, 2'b00};
    else                 seq_D = pipe_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ZERO;
      pipe_op_q    <= '0;
      pipe_cc_q    <= '0;
      pipe_pol_q   <= 1'b0;
      pipe_rld_q   <= 1'b0;
      pipe_addr_q  <= '0;
      pipe_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        pipe_op_q    <= uw_op;
        pipe_cc_q    <= uw_cc;
        pipe_pol_q   <= uw_pol;
        pipe_rld_q   <= uw_rld;
        pipe_addr_q  <= uw_addr;
        pipe_valid_q <= 1'b1;
      end
    end
  end

  // An ack registered just before reset must not escape while reset is held.
  assign irq_ack    = reset ? '0 : arb_ack;
  assign pipe_valid = pipe_valid_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_useq_control.sv
// Bench for useq_control: the bench acts as control store and sequencer,
// driving microwords and source enables and checking the front-end outputs.
module tb_useq_control;
  import useq_pkg::*;

  localparam int NIRQ  = 8;
  localparam int NCOND = 15;

  logic             clk = 1'b0;
  logic             reset, run, step;
  logic             halted, pipe_valid;
  logic [3:0]       uw_op, uw_cc;
  logic             uw_pol, uw_rld;
  logic [11:0]      uw_addr, map_addr;
  logic [NCOND-1:0] cond;
  logic [NIRQ-1:0]  irq, irq_ack;
  logic [3:0]       seq_I;
  logic             seq_nCCEN, seq_nCC, seq_nRLD, seq_CI;
  logic [11:0]      seq_D;
  logic             seq_nPL, seq_nVECT, seq_nMAP;
  state_t           dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  logic [NIRQ-1:0] exp_q[$];
  logic [NIRQ-1:0] exp_ack;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  useq_control #(.NIRQ(NIRQ), .NCOND(NCOND), .VECT_BASE(12'h100)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .halted(halted), .pipe_valid(pipe_valid),
    .uw_op(uw_op), .uw_cc(uw_cc), .uw_pol(uw_pol), .uw_rld(uw_rld),
    .uw_addr(uw_addr), .map_addr(map_addr), .cond(cond),
    .irq(irq), .irq_ack(irq_ack),
    .seq_I(seq_I), .seq_nCCEN(seq_nCCEN), .seq_nCC(seq_nCC),
    .seq_nRLD(seq_nRLD), .seq_CI(seq_CI), .seq_D(seq_D),
    .seq_nPL(seq_nPL), .seq_nVECT(seq_nVECT), .seq_nMAP(seq_nMAP),
    .dbg_state(dbg_state)
  );

  // driver: place a word on the control-store bus, let one issue edge load it
  // into the pipeline, then return mid-cycle with a CONT filler on the bus.
  task automatic present(input logic [3:0] op, input logic [3:0] cc, input logic pol,
                         input logic rld, input logic [11:0] addr);
    uw_op = op; uw_cc = cc; uw_pol = pol; uw_rld = rld; uw_addr = addr;
    @(posedge clk); #1;
    uw_op = 4'(CONT); uw_cc = CC_ALWAYS; uw_pol = 1'b0; uw_rld = 1'b0; uw_addr = 12'h000;
  endtask

  task automatic test_reset;
    reset = 1'b1; run = 1'b1;
    uw_op = 4'(CJP); uw_cc = CC_ALWAYS; uw_pol = 1'b0; uw_rld = 1'b0; uw_addr = 12'h010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (seq_I !== 4'(JZ)) begin miscompares++; $display("FAIL rst_I got %h want %h", seq_I, 4'(JZ)); end
      vectors++; if (seq_CI !== 1'b0) begin miscompares++; $display("FAIL rst_CI got %b want 0", seq_CI); end
      vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL rst_halted got %b want 1", halted); end
      vectors++; if (irq_ack !== 8'h00) begin miscompares++; $display("FAIL rst_ack got %h want 00", irq_ack); end
      vectors++; if ({seq_nCCEN, seq_nCC, seq_nRLD} !== 3'b111) begin miscompares++; $display("FAIL rst_ctl got %b want 111", {seq_nCCEN, seq_nCC, seq_nRLD}); end
      vectors++; if (pipe_valid !== 1'b0) begin miscompares++; $display("FAIL rst_pv got %b want 0", pipe_valid); end
    end
    @(posedge clk); #1; reset = 1'b0; #2;
    vectors++; if (seq_I !== 4'(JZ) || seq_CI !== 1'b1) begin miscompares++; $display("FAIL zero_I_CI got %h/%b want 0/1", seq_I, seq_CI); end
    vectors++; if (halted !== 1'b1 || pipe_valid !== 1'b0) begin miscompares++; $display("FAIL zero_status got %b%b want 10", halted, pipe_valid); end
    @(posedge clk); #1;
    uw_op = 4'(LDCT); uw_cc = CC_ALWAYS; uw_pol = 1'b0; uw_rld = 1'b1; uw_addr = 12'h020; #2;
    vectors++; if (pipe_valid !== 1'b1) begin miscompares++; $display("FAIL first_pv got %b want 1", pipe_valid); end
    vectors++; if (seq_I !== 4'(CJP) || seq_CI !== 1'b1) begin miscompares++; $display("FAIL first_I got %h/%b want 3/1", seq_I, seq_CI); end
    vectors++; if (halted !== 1'b0 || seq_D !== 12'h010) begin miscompares++; $display("FAIL first_D got %b/%h want 0/010", halted, seq_D); end
    @(posedge clk); #1;
    uw_op = 4'(CONT); uw_rld = 1'b0; uw_addr = 12'h000; #2;
    vectors++; if (seq_I !== 4'(LDCT) || seq_nRLD !== 1'b0) begin miscompares++; $display("FAIL rld got %h/%b want c/0", seq_I, seq_nRLD); end
  endtask

  task automatic test_halt_step;
    present(4'(CJS), CC_ALWAYS, 1'b0, 1'b0, 12'h055);
    run = 1'b0;
    uw_op = 4'(JMAP); uw_addr = 12'h066; #2;
    vectors++; if (seq_I !== 4'(CJS) || seq_CI !== 1'b1) begin miscompares++; $display("FAIL lastrun got %h/%b want 1/1", seq_I, seq_CI); end
    @(posedge clk); #1;
    uw_op = 4'(TWB); uw_addr = 12'h0EE;
    for (int i = 0; i < 10; i++) begin
      #2;
      vectors++; if (seq_I !== 4'(CONT) || seq_CI !== 1'b0) begin miscompares++; $display("FAIL hold_I got %h/%b want e/0", seq_I, seq_CI); end
      vectors++; if ({seq_nRLD, seq_nCCEN, halted, pipe_valid} !== 4'b1111) begin miscompares++; $display("FAIL hold_ctl got %b want 1111", {seq_nRLD, seq_nCCEN, halted, pipe_valid}); end
      vectors++; if (seq_D !== 12'h066) begin miscompares++; $display("FAIL hold_pipe got %h want 066", seq_D); end
      @(posedge clk); #1;
    end
    step = 1'b1; #2;
    vectors++; if (seq_I !== 4'(CONT)) begin miscompares++; $display("FAIL step_req got %h want e", seq_I); end
    @(posedge clk); #1;
    step = 1'b0; uw_op = 4'(PUSH); uw_addr = 12'h077; #2;
    vectors++; if (seq_I !== 4'(JMAP) || seq_CI !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("FAIL step_issue got %h/%b/%b want 2/1/0", seq_I, seq_CI, halted); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; #2;
      vectors++; if (seq_I !== 4'(CONT) || halted !== 1'b1 || seq_D !== 12'h077) begin miscompares++; $display("FAIL after_step got %h/%b/%h want e/1/077", seq_I, halted, seq_D); end
    end
    run = 1'b1; step = 1'b1;
    @(posedge clk); #1; step = 1'b0; #2;
    vectors++; if (seq_I !== 4'(PUSH) || halted !== 1'b0) begin miscompares++; $display("FAIL run_wins got %h/%b want 4/0", seq_I, halted); end
    @(posedge clk); #1;
    uw_op = 4'(CONT); uw_addr = 12'h000; #2;
    vectors++; if (halted !== 1'b0 || seq_CI !== 1'b1) begin miscompares++; $display("FAIL still_run got %b/%b want 0/1", halted, seq_CI); end
  endtask

  task automatic test_cond;
    cond = 15'h0004;
    present(4'(CJP), 4'd3, 1'b0, 1'b0, 12'h020); #2;
    vectors++; if (seq_nCCEN !== 1'b0 || seq_nCC !== 1'b0) begin miscompares++; $display("FAIL cc3_pass got %b%b want 00", seq_nCCEN, seq_nCC); end
    cond = 15'h0000; #1;
    vectors++; if (seq_nCC !== 1'b1) begin miscompares++; $display("FAIL cc3_fail got %b want 1", seq_nCC); end
    cond = 15'h0004;
    present(4'(CJP), 4'd3, 1'b1, 1'b0, 12'h020); #2;
    vectors++; if (seq_nCCEN !== 1'b0 || seq_nCC !== 1'b1) begin miscompares++; $display("FAIL cc3_pol got %b%b want 01", seq_nCCEN, seq_nCC); end
    present(4'(CJP), CC_ALWAYS, 1'b0, 1'b0, 12'h020); #2;
    vectors++; if (seq_nCCEN !== 1'b1) begin miscompares++; $display("FAIL cc0 got %b want 1", seq_nCCEN); end
    cond = 15'h2000;
    present(4'(CJP), 4'd14, 1'b0, 1'b0, 12'h020); #2;
    vectors++; if (seq_nCCEN !== 1'b0 || seq_nCC !== 1'b0) begin miscompares++; $display("FAIL cc14 got %b%b want 00", seq_nCCEN, seq_nCC); end
    cond = 15'h0000;
    present(4'(CJP), CC_IRQ, 1'b0, 1'b0, 12'h020); #2;
    vectors++; if (seq_nCCEN !== 1'b0 || seq_nCC !== 1'b1) begin miscompares++; $display("FAIL cc15_idle got %b%b want 01", seq_nCCEN, seq_nCC); end
  endtask

  task automatic test_irq;
    irq = 8'b0010_0100;
    @(posedge clk); #1; irq = 8'h00;
    present(4'(CJV), CC_IRQ, 1'b0, 1'b0, 12'h0AA);
    seq_nVECT = 1'b0; #2;
    vectors++; if (seq_nCC !== 1'b0 || seq_D !== 12'h108) begin miscompares++; $display("FAIL cjv1 got %b/%h want 0/108", seq_nCC, seq_D); end
    vectors++; if (irq_ack !== 8'h00) begin miscompares++; $display("FAIL cjv1_noack got %h want 00", irq_ack); end
    exp_q.push_back(8'b0000_0100);
    present(4'(CJV), CC_IRQ, 1'b0, 1'b0, 12'h0AA); #2;
    exp_ack = exp_q.pop_front();
    vectors++; if (irq_ack !== exp_ack) begin miscompares++; $display("FAIL ack1 got %h want %h", irq_ack, exp_ack); end
    vectors++; if (seq_nCC !== 1'b0 || seq_D !== 12'h114) begin miscompares++; $display("FAIL cjv2 got %b/%h want 0/114", seq_nCC, seq_D); end
    exp_q.push_back(8'b0010_0000);
    present(4'(CJV), CC_IRQ, 1'b0, 1'b0, 12'h0AA); #2;
    exp_ack = exp_q.pop_front();
    vectors++; if (irq_ack !== exp_ack) begin miscompares++; $display("FAIL ack2 got %h want %h", irq_ack, exp_ack); end
    vectors++; if (seq_nCC !== 1'b1) begin miscompares++; $display("FAIL cjv3 got %b want 1", seq_nCC); end
    exp_q.push_back(8'h00);
    @(posedge clk); #1; #2;
    exp_ack = exp_q.pop_front();
    vectors++; if (irq_ack !== exp_ack) begin miscompares++; $display("FAIL ack3 got %h want %h", irq_ack, exp_ack); end
    // a new pulse on the granted line during the grant cycle re-pends it
    irq = 8'h01;
    @(posedge clk); #1; irq = 8'h00;
    present(4'(CJV), CC_IRQ, 1'b0, 1'b0, 12'h0AA);
    irq = 8'h01; #2;
    vectors++; if (seq_nCC !== 1'b0 || seq_D !== 12'h100) begin miscompares++; $display("FAIL rp_grant got %b/%h want 0/100", seq_nCC, seq_D); end
    exp_q.push_back(8'h01);
    present(4'(CJV), CC_IRQ, 1'b0, 1'b0, 12'h0AA);
    irq = 8'h00; #2;
    exp_ack = exp_q.pop_front();
    vectors++; if (irq_ack !== exp_ack) begin miscompares++; $display("FAIL rp_ack1 got %h want %h", irq_ack, exp_ack); end
    vectors++; if (seq_nCC !== 1'b0 || seq_D !== 12'h100) begin miscompares++; $display("FAIL rp_repend got %b/%h want 0/100", seq_nCC, seq_D); end
    exp_q.push_back(8'h01);
    @(posedge clk); #1; #2;
    exp_ack = exp_q.pop_front();
    vectors++; if (irq_ack !== exp_ack) begin miscompares++; $display("FAIL rp_ack2 got %h want %h", irq_ack, exp_ack); end
    seq_nVECT = 1'b1;
  endtask

  task automatic test_dmux;
    present(4'(CONT), CC_ALWAYS, 1'b0, 1'b0, 12'h07F);
    map_addr = 12'h3A5; seq_nMAP = 1'b0; #2;
    vectors++; if (seq_D !== 12'h3A5) begin miscompares++; $display("FAIL d_map got %h want 3a5", seq_D); end
    seq_nVECT = 1'b0; #1;
    vectors++; if (seq_D !== 12'h3A5) begin miscompares++; $display("FAIL d_prio got %h want 3a5", seq_D); end
    seq_nMAP = 1'b1; #1;
    vectors++; if (seq_D !== 12'h100) begin miscompares++; $display("FAIL d_vect0 got %h want 100", seq_D); end
    seq_nVECT = 1'b1; #1;
    vectors++; if (seq_D !== 12'h07F) begin miscompares++; $display("FAIL d_pipe got %h want 07f", seq_D); end
  endtask

  task automatic test_reset_mid;
    irq = 8'h81;
    @(posedge clk); #1; irq = 8'h00;
    present(4'(CJV), CC_IRQ, 1'b0, 1'b0, 12'h0AA);
    reset = 1'b1; #2;
    vectors++; if (irq_ack !== 8'h00 || seq_I !== 4'(JZ) || seq_CI !== 1'b0) begin miscompares++; $display("FAIL mid_rst got %h/%h/%b want 00/0/0", irq_ack, seq_I, seq_CI); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; #2;
      vectors++; if (irq_ack !== 8'h00 || pipe_valid !== 1'b0) begin miscompares++; $display("FAIL mid_hold got %h/%b want 00/0", irq_ack, pipe_valid); end
    end
    uw_op = 4'(CJP); uw_cc = CC_ALWAYS; uw_addr = 12'h010;
    @(posedge clk); #1; reset = 1'b0; #2;
    vectors++; if (seq_I !== 4'(JZ) || seq_CI !== 1'b1 || irq_ack !== 8'h00) begin miscompares++; $display("FAIL mid_zero got %h/%b/%h want 0/1/00", seq_I, seq_CI, irq_ack); end
    @(posedge clk); #1;
    uw_op = 4'(CONT); uw_addr = 12'h000; #2;
    vectors++; if (seq_I !== 4'(CJP) || pipe_valid !== 1'b1) begin miscompares++; $display("FAIL mid_restart got %h/%b want 3/1", seq_I, pipe_valid); end
    present(4'(CJV), CC_IRQ, 1'b0, 1'b0, 12'h0AA); #2;
    vectors++; if (seq_nCC !== 1'b1) begin miscompares++; $display("FAIL mid_pend got %b want 1", seq_nCC); end
    exp_q.push_back(8'h00);
    @(posedge clk); #1; #2;
    exp_ack = exp_q.pop_front();
    vectors++; if (irq_ack !== exp_ack) begin miscompares++; $display("FAIL mid_ack got %h want %h", irq_ack, exp_ack); end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0;
    uw_op = 4'(CONT); uw_cc = CC_ALWAYS; uw_pol = 1'b0; uw_rld = 1'b0; uw_addr = 12'h000;
    map_addr = 12'h000; cond = '0; irq = '0;
    seq_nPL = 1'b0; seq_nVECT = 1'b1; seq_nMAP = 1'b1;
    test_reset();
    test_halt_step();
    test_cond();
    test_irq();
    test_dmux();
    test_reset_mid();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_drain got %0d want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
